pu_pio_bridge: RTL and testbench

//  Host-facing PIO master for the PU register/memory space; sits directly upstream of the PU PIO decoder.

---
 rtl/pu_pio_bridge_if.sv | 32 +++
 rtl/pu_pio_bridge.sv | 135 +++++++++++++
 tb/tb_pu_pio_bridge.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pu_pio_bridge_if.sv
// Host request/response bundle and PIO decoder bundle used by pu_pio_bridge.
interface pu_host_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              host_req;
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rsp_rdata;
  logic              host_rsp_err;

  modport master (output host_req, host_wr, host_addr, host_wdata,
                  input  host_gnt, host_rsp_valid, host_rsp_rdata, host_rsp_err);
  modport slave  (input  host_req, host_wr, host_addr, host_wdata,
                  output host_gnt, host_rsp_valid, host_rsp_rdata, host_rsp_err);
endinterface

interface pu_pio_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              reg_bs;
  logic              reg_rd;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_din;
  logic              pio_ack;
  logic              pio_rvalid;
  logic [DATA_W-1:0] pio_rdata;

  modport master (output reg_bs, reg_rd, reg_wr, reg_addr, reg_din,
                  input  pio_ack, pio_rvalid, pio_rdata);
  modport slave  (input  reg_bs, reg_rd, reg_wr, reg_addr, reg_din,
                  output pio_ack, pio_rvalid, pio_rdata);
endinterface

// File: rtl/pu_pio_bridge.sv
// Host-to-PU PIO master: one outstanding request, strobes decoder, returns a one-cycle response.
// Latency: reg strobes one cycle after accept, response one cycle after decoder completion.
// Backpressure: host_gnt only in IDLE; response has none. PU_PIO_TIMEOUT_EN adds a WAIT timeout abort.
module pu_pio_bridge #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = DATA_W'(32'hDEAD_BEEF)
) (
  input logic       clk,
  input logic       rst_n,
  pu_host_if.slave  host,
  pu_pio_if.master  pio
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              bs_q, bs_d;
  logic              rd_q, rd_d;
  logic              wstb_q, wstb_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              accept;
  logic              done;
  logic              timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("pu_pio_bridge: TIMEOUT_CYCLES must be >= 2");
  end

`ifdef PU_PIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (state_q == S_ISSUE) cnt_q <= '0;
    else if (state_q == S_WAIT)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign timeout = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    din_d     = din_q;
    bs_d      = 1'b0;
    rd_d      = 1'b0;
    wstb_d    = 1'b0;
    rsp_vld_d = 1'b0;
    rsp_err_d = 1'b0;
    rsp_dat_d = '0;
    accept    = host.host_req && (state_q == S_IDLE);
    // only the indication matching the request type counts as completion
    done      = wr_q ? pio.pio_ack : pio.pio_rvalid;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          wr_d    = host.host_wr;
          addr_d  = host.host_addr;
          din_d   = host.host_wdata;
          bs_d    = 1'b1;
          rd_d    = !host.host_wr;
          wstb_d  = host.host_wr;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        bs_d    = 1'b1;
      end
      S_WAIT: begin
        if (done || timeout) begin
          state_d   = S_DRAIN;
          rsp_vld_d = 1'b1;
          rsp_err_d = !done;
          if (!wr_q) rsp_dat_d = done ? pio.pio_rdata : TIMEOUT_DATA;
        end else begin
          bs_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // sticky decoder indications must clear before the next request
        if (!pio.pio_ack && !pio.pio_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      bs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wstb_q    <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      bs_q      <= bs_d;
      rd_q      <= rd_d;
      wstb_q    <= wstb_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= rsp_err_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign host.host_gnt       = (state_q == S_IDLE);
  assign host.host_rsp_valid = rsp_vld_q;
  assign host.host_rsp_rdata = rsp_dat_q;
  assign host.host_rsp_err   = rsp_err_q;
  assign pio.reg_bs          = bs_q;
  assign pio.reg_rd          = rd_q;
  assign pio.reg_wr          = wstb_q;
  assign pio.reg_addr        = addr_q;
  assign pio.reg_din         = din_q;

endmodule

// File: tb/tb_pu_pio_bridge.sv
// Directed bench for pu_pio_bridge; cycle numbers count from the request cycle (0).
module tb_pu_pio_bridge;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pu_host_if #(.ADDR_W(32), .DATA_W(32)) hif();
  pu_pio_if  #(.ADDR_W(32), .DATA_W(32)) pif();

  pu_pio_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16),
                  .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n), .host(hif), .pio(pif));

  int errors = 0;
  int checks = 0;

  int          n_wr, n_rd, n_bs, n_rsp, wr_cyc, rd_cyc, bs_last, rsp_cyc, gnt_cyc;
  logic [31:0] rsp_rdata, issue_addr, issue_din;
  logic        rsp_err, pre_gnt, bs_final;

  // Issues one request in cycle 0 and plays decoder indications from bit masks (bit c = cycle c).
  task automatic drive_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] ack_m, input logic [31:0] rv_m,
                           input logic [31:0] rd_dat, input int ncyc);
    n_wr = 0; n_rd = 0; n_bs = 0; n_rsp = 0;
    wr_cyc = -1; rd_cyc = -1; bs_last = -1; rsp_cyc = -1; gnt_cyc = -1;
    rsp_rdata = 32'hx; rsp_err = 1'bx; issue_addr = 32'h0; issue_din = 32'h0;
    @(negedge clk);
    hif.host_req = 1'b1; hif.host_wr = wr; hif.host_addr = addr; hif.host_wdata = wdata;
    pre_gnt = hif.host_gnt;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      hif.host_req = 1'b0;
      if (pif.reg_wr === 1'b1) begin n_wr++; wr_cyc = c; end
      if (pif.reg_rd === 1'b1) begin n_rd++; rd_cyc = c; end
      if (pif.reg_bs === 1'b1) begin n_bs++; bs_last = c; end
      if (hif.host_rsp_valid === 1'b1) begin
        n_rsp++; rsp_cyc = c; rsp_rdata = hif.host_rsp_rdata; rsp_err = hif.host_rsp_err;
      end
      if (hif.host_gnt === 1'b1 && gnt_cyc < 0) gnt_cyc = c;
      if (c == 1) begin issue_addr = pif.reg_addr; issue_din = pif.reg_din; end
      pif.pio_ack    = (c < 32) ? ack_m[c] : 1'b0;
      pif.pio_rvalid = (c < 32) ? rv_m[c]  : 1'b0;
      pif.pio_rdata  = pif.pio_rvalid ? rd_dat : ~rd_dat;
    end
    bs_final = pif.reg_bs;
    pif.pio_ack = 1'b0; pif.pio_rvalid = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    hif.host_req = 1'b0; hif.host_wr = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
    pif.pio_ack = 1'b0; pif.pio_rvalid = 1'b0; pif.pio_rdata = '0;
    #12;
    checks++; if (pif.reg_bs !== 1'b0) begin errors++; $display("FAIL rst_bs: got %b expected 0", pif.reg_bs); end
    checks++; if (pif.reg_rd !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b expected 0", pif.reg_rd); end
    checks++; if (pif.reg_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b expected 0", pif.reg_wr); end
    checks++; if (pif.reg_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", pif.reg_addr); end
    checks++; if (pif.reg_din !== 32'h0) begin errors++; $display("FAIL rst_din: got %h expected 0", pif.reg_din); end
    checks++; if (hif.host_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", hif.host_rsp_valid); end
    checks++; if (hif.host_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0", hif.host_rsp_rdata); end
    checks++; if (hif.host_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", hif.host_rsp_err); end
    checks++; if (hif.host_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt: got %b expected 1", hif.host_gnt); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // reg_wr cycle 1, ack cycles 4-5: bs 1..4, rsp cycle 5, DRAIN 5-6, gnt back cycle 7
  task automatic test_write;
    drive_txn(1'b1, 32'h0000_1004, 32'hA5A5_0001, 32'h0000_0030, 32'h0, 32'h0, 9);
    checks++; if (pre_gnt !== 1'b1) begin errors++; $display("FAIL wr_pre_gnt: got %b expected 1", pre_gnt); end
    checks++; if (n_wr !== 1 || wr_cyc !== 1) begin errors++; $display("FAIL wr_strobe: got count %0d cycle %0d expected 1 at 1", n_wr, wr_cyc); end
    checks++; if (n_rd !== 0) begin errors++; $display("FAIL wr_no_rd: got %0d expected 0", n_rd); end
    checks++; if (issue_addr !== 32'h0000_1004) begin errors++; $display("FAIL wr_addr: got %h expected 00001004", issue_addr); end
    checks++; if (issue_din !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_din: got %h expected a5a50001", issue_din); end
    checks++; if (n_bs !== 4 || bs_last !== 4) begin errors++; $display("FAIL wr_bs: got %0d cycles last %0d expected 4 last 4", n_bs, bs_last); end
    checks++; if (n_rsp !== 1 || rsp_cyc !== 5) begin errors++; $display("FAIL wr_rsp: got %0d at %0d expected 1 at 5", n_rsp, rsp_cyc); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_data: got %h err %b expected 0 err 0", rsp_rdata, rsp_err); end
    checks++; if (gnt_cyc !== 7) begin errors++; $display("FAIL wr_gnt_return: got %0d expected 7", gnt_cyc); end
  endtask

  // reg_rd cycle 1, rvalid cycle 3: rsp cycle 4, gnt back cycle 5
  task automatic test_read;
    drive_txn(1'b0, 32'h0000_2000, 32'h0, 32'h0, 32'h0000_0008, 32'h1234_5678, 8);
    checks++; if (n_rd !== 1 || rd_cyc !== 1) begin errors++; $display("FAIL rd_strobe: got count %0d cycle %0d expected 1 at 1", n_rd, rd_cyc); end
    checks++; if (n_wr !== 0) begin errors++; $display("FAIL rd_no_wr: got %0d expected 0", n_wr); end
    checks++; if (issue_addr !== 32'h0000_2000) begin errors++; $display("FAIL rd_addr: got %h expected 00002000", issue_addr); end
    checks++; if (n_rsp !== 1 || rsp_cyc !== 4) begin errors++; $display("FAIL rd_rsp: got %0d at %0d expected 1 at 4", n_rsp, rsp_cyc); end
    checks++; if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_data: got %h err %b expected 12345678 err 0", rsp_rdata, rsp_err); end
    checks++; if (bs_last !== 3 || gnt_cyc !== 5) begin errors++; $display("FAIL rd_bs_gnt: got bs_last %0d gnt %0d expected 3 and 5", bs_last, gnt_cyc); end
  endtask

  // Two writes with req held; decoder acks for one cycle, the cycle after reg_wr.
  task automatic test_back_to_back;
    int          acc_n, nrsp, nlog;
    int          acc_cyc[2];
    logic [31:0] log_addr[2];
    logic        wr_prev;
    acc_n = 0; nrsp = 0; nlog = 0; wr_prev = 1'b0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; log_addr[0] = '0; log_addr[1] = '0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      pif.pio_ack = wr_prev;
      wr_prev = pif.reg_wr;
      if (pif.reg_wr === 1'b1 && nlog < 2) begin log_addr[nlog] = pif.reg_addr; nlog++; end
      if (hif.host_rsp_valid === 1'b1) nrsp++;
      hif.host_wr = 1'b1;
      hif.host_req = (acc_n < 2);
      hif.host_addr = (acc_n == 0) ? 32'h0000_0100 : 32'h0000_0200;
      hif.host_wdata = hif.host_addr ^ 32'h5555_0000;
      if (hif.host_req && hif.host_gnt === 1'b1) begin acc_cyc[acc_n] = c; acc_n++; end
    end
    hif.host_req = 1'b0; pif.pio_ack = 1'b0;
    checks++; if (acc_n !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_n); end
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 4) begin errors++; $display("FAIL b2b_gap: got %0d expected 4", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (log_addr[0] !== 32'h0000_0100) begin errors++; $display("FAIL b2b_order0: got %h expected 00000100", log_addr[0]); end
    checks++; if (log_addr[1] !== 32'h0000_0200) begin errors++; $display("FAIL b2b_order1: got %h expected 00000200", log_addr[1]); end
    checks++; if (nrsp !== 2) begin errors++; $display("FAIL b2b_rsp_count: got %0d expected 2", nrsp); end
  endtask

  // pio_ack in cycles 2-4 of a read is ignored; rvalid cycle 6 completes, rsp cycle 7
  task automatic test_wrong_type;
    drive_txn(1'b0, 32'h0000_2400, 32'h0, 32'h0000_001C, 32'h0000_0040, 32'hCAFE_0042, 10);
    checks++; if (n_rsp !== 1 || rsp_cyc !== 7) begin errors++; $display("FAIL wt_rsp: got %0d at %0d expected 1 at 7", n_rsp, rsp_cyc); end
    checks++; if (rsp_rdata !== 32'hCAFE_0042 || rsp_err !== 1'b0) begin errors++; $display("FAIL wt_rsp_data: got %h err %b expected cafe0042 err 0", rsp_rdata, rsp_err); end
    checks++; if (bs_last !== 6) begin errors++; $display("FAIL wt_bs_last: got %0d expected 6", bs_last); end
    checks++; if (gnt_cyc !== 8) begin errors++; $display("FAIL wt_gnt_return: got %0d expected 8", gnt_cyc); end
  endtask

  task automatic test_timeout;
`ifdef PU_PIO_TIMEOUT_EN
    // ISSUE cycle 1, WAIT 2..17 (count 0..15), rsp cycle 18
    drive_txn(1'b0, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 32'h0, 22);
    checks++; if (n_rsp !== 1 || rsp_cyc !== 18) begin errors++; $display("FAIL to_rd_rsp: got %0d at %0d expected 1 at 18", n_rsp, rsp_cyc); end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b1) begin errors++; $display("FAIL to_rd_data: got %h err %b expected deadbeef err 1", rsp_rdata, rsp_err); end
    checks++; if (bs_last !== 17 || gnt_cyc !== 19) begin errors++; $display("FAIL to_rd_bs_gnt: got %0d and %0d expected 17 and 19", bs_last, gnt_cyc); end
    drive_txn(1'b1, 32'h0000_4004, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 22);
    checks++; if (n_rsp !== 1 || rsp_cyc !== 18) begin errors++; $display("FAIL to_wr_rsp: got %0d at %0d expected 1 at 18", n_rsp, rsp_cyc); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b1) begin errors++; $display("FAIL to_wr_data: got %h err %b expected 0 err 1", rsp_rdata, rsp_err); end
`else
    drive_txn(1'b0, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 32'h0, 1000);
    checks++; if (n_rsp !== 0) begin errors++; $display("FAIL nto_rsp: got %0d expected 0", n_rsp); end
    checks++; if (bs_final !== 1'b1) begin errors++; $display("FAIL nto_bs_held: got %b expected 1", bs_final); end
    checks++; if (gnt_cyc !== -1) begin errors++; $display("FAIL nto_gnt: got %0d expected -1", gnt_cyc); end
    apply_reset();
`endif
  endtask

  task automatic test_reset_mid;
    int nrsp, nbs, ngnt_low;
    nrsp = 0; nbs = 0; ngnt_low = 0;
    @(negedge clk);
    hif.host_req = 1'b1; hif.host_wr = 1'b0; hif.host_addr = 32'h0000_3000;
    @(negedge clk); hif.host_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pif.reg_bs !== 1'b1) begin errors++; $display("FAIL rm_in_wait: got %b expected 1", pif.reg_bs); end
    rst_n = 1'b0;
    #1;
    checks++; if (pif.reg_bs !== 1'b0) begin errors++; $display("FAIL rm_bs: got %b expected 0", pif.reg_bs); end
    checks++; if (pif.reg_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h expected 0", pif.reg_addr); end
    checks++; if (pif.reg_rd !== 1'b0 || pif.reg_wr !== 1'b0) begin errors++; $display("FAIL rm_strobes: got %b%b expected 00", pif.reg_rd, pif.reg_wr); end
    checks++; if (hif.host_rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid: got %b expected 0", hif.host_rsp_valid); end
    checks++; if (hif.host_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b expected 1", hif.host_gnt); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); pif.pio_ack = 1'b1; pif.pio_rvalid = 1'b1; pif.pio_rdata = 32'h7777_7777;
    @(negedge clk); pif.pio_ack = 1'b0; pif.pio_rvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (hif.host_rsp_valid === 1'b1) nrsp++;
      if (pif.reg_bs === 1'b1) nbs++;
      if (hif.host_gnt !== 1'b1) ngnt_low++;
      @(negedge clk);
    end
    checks++; if (nrsp !== 0) begin errors++; $display("FAIL rm_stale_rsp: got %0d expected 0", nrsp); end
    checks++; if (nbs !== 0) begin errors++; $display("FAIL rm_stale_bs: got %0d expected 0", nbs); end
    checks++; if (ngnt_low !== 0) begin errors++; $display("FAIL rm_stale_gnt: got %0d low cycles expected 0", ngnt_low); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_wrong_type();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
